// File: rtl/lda_avalon_slave.sv
// Avalon-MM register block in front of the line-drawing core: stages the
// endpoints, colour and mode, snapshots them on GO, pulses o_GO, and tracks
// completion either by stalling the GO write or through a pollable busy bit.
module lda_avalon_slave (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  i_avs_address,
   input  logic        i_avs_read,
   input  logic        i_avs_write,
   input  logic [31:0] i_avs_writedata,
   output logic [31:0] o_avs_readdata,
   output logic        o_avs_waitrequest,
   output logic [8:0]  o_X0,
   output logic [8:0]  o_Y0,
   output logic [8:0]  o_X1,
   output logic [8:0]  o_Y1,
   output logic [2:0]  o_COLOR,
   output logic        o_GO,
   input  logic        i_DONE
);

   localparam logic [2:0] ADDR_MODE   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd1;
   localparam logic [2:0] ADDR_GO     = 3'd2;
   localparam logic [2:0] ADDR_START  = 3'd3;
   localparam logic [2:0] ADDR_END    = 3'd4;
   localparam logic [2:0] ADDR_COLOR  = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FINISH
   } state_t;

   state_t     state;
   state_t     state_next;

   // staging registers written by the processor
   logic       mode;          // 0 = stall on GO, 1 = poll STATUS
   logic [8:0] start_x;
   logic [8:0] start_y;
   logic [8:0] end_x;
   logic [8:0] end_y;
   logic [2:0] color;

   logic       go_write;
   logic       go_start;
   logic       write_ok;
   logic       busy;

   // writedata bits above the widest field carry no information
   logic       unused_ok;
   assign unused_ok = &{1'b0, i_avs_writedata[31:18]};

   assign go_write = i_avs_write && (i_avs_address == ADDR_GO);
   assign busy     = (state != IDLE);

   // A stall-mode GO is held from issue until the FINISH cycle; reset
   // releases any pending stall immediately.
   assign o_avs_waitrequest = reset && go_write && !mode && (state != FINISH);
   assign write_ok          = i_avs_write && !o_avs_waitrequest;

   // Next-state logic: GO in IDLE starts a line, DONE in BUSY finishes it.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can leave it unassigned (no latches).
      state_next = state;
      go_start   = 1'b0;
      case (state)
         IDLE: begin
            if (go_write) begin
               go_start   = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (i_DONE) begin
               state_next = FINISH;
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples the pre-edge values of its neighbours.
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Staging registers accept writes whenever the bus is not stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode    <= 1'b0;
         start_x <= '0;
         start_y <= '0;
         end_x   <= '0;
         end_y   <= '0;
         color   <= '0;
      end else if (write_ok) begin
         case (i_avs_address)
            ADDR_MODE:  mode <= i_avs_writedata[0];
            ADDR_START: begin
               start_x <= i_avs_writedata[8:0];
               start_y <= i_avs_writedata[17:9];
            end
            ADDR_END: begin
               end_x <= i_avs_writedata[8:0];
               end_y <= i_avs_writedata[17:9];
            end
            ADDR_COLOR: color <= i_avs_writedata[2:0];
            default: ;
         endcase
      end
   end

   // Shadow copies seen by the LDA only change when a line is started.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_GO    <= 1'b0;
         o_X0    <= '0;
         o_Y0    <= '0;
         o_X1    <= '0;
         o_Y1    <= '0;
         o_COLOR <= '0;
      end else begin
         o_GO <= go_start;
         if (go_start) begin
            o_X0    <= start_x;
            o_Y0    <= start_y;
            o_X1    <= end_x;
            o_Y1    <= end_y;
            o_COLOR <= color;
         end
      end
   end

   // Combinational read mux, zero-extended, zero when not reading.
   always_comb begin
      o_avs_readdata = '0;
      if (i_avs_read) begin
         case (i_avs_address)
            ADDR_MODE:   o_avs_readdata = {31'd0, mode};
            ADDR_STATUS: o_avs_readdata = {31'd0, busy};
            ADDR_START:  o_avs_readdata = {14'd0, start_y, start_x};
            ADDR_END:    o_avs_readdata = {14'd0, end_y, end_x};
            ADDR_COLOR:  o_avs_readdata = {29'd0, color};
            default:     o_avs_readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_lda_avalon_slave.sv
// Bench for lda_avalon_slave: a timestamp-based model of the register block
// is checked against the DUT on every cycle, plus literal expectations for
// the directed scenarios. An LDA stand-in answers each o_GO after a delay.
module tb_lda_avalon_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        waitreq;
   logic [8:0]  x0, y0, x1, y1;
   logic [2:0]  col;
   logic        go;
   logic        lda_done = 1'b0;
   logic        stray_done = 1'b0;
   logic        done_w;

   int compared = 0;
   int mismatched = 0;
   int go_count = 0;
   int lda_delay = 1;

   assign done_w = lda_done | stray_done;

   lda_avalon_slave dut (
      .clk               (clk),
      .reset             (reset),
      .i_avs_address     (addr),
      .i_avs_read        (rd),
      .i_avs_write       (wr),
      .i_avs_writedata   (wdata),
      .o_avs_readdata    (rdata),
      .o_avs_waitrequest (waitreq),
      .o_X0              (x0),
      .o_Y0              (y0),
      .o_X1              (x1),
      .o_Y1              (y1),
      .o_COLOR           (col),
      .o_GO              (go),
      .i_DONE            (done_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A line is described by the edge it was accepted at and the edge DONE
   // was seen at; busy spans go_cyc..done_cyc inclusive (done_cyc is FINISH).
   int         cyc = 0;
   int         go_cyc = -1;
   int         done_cyc = -1;
   int         go_pulse = -1;
   logic       m_mode = 1'b0;
   logic [8:0] m_sx0 = '0, m_sy0 = '0, m_sx1 = '0, m_sy1 = '0;
   logic [2:0] m_scol = '0;
   logic [8:0] m_x0 = '0, m_y0 = '0, m_x1 = '0, m_y1 = '0;
   logic [2:0] m_col = '0;

   function automatic logic m_busy(input int c);
      return (go_cyc >= 0) && (c >= go_cyc) && ((done_cyc < 0) || (c <= done_cyc));
   endfunction

   function automatic logic m_finish(input int c);
      return (done_cyc >= 0) && (c == done_cyc);
   endfunction

   function automatic logic m_wait(input int c);
      return reset && wr && (addr == 3'd2) && !m_mode && !m_finish(c);
   endfunction

   function automatic logic [31:0] m_rdata(input int c);
      if (!rd) return 32'd0;
      case (addr)
         3'd0:    return {31'd0, m_mode};
         3'd1:    return {31'd0, m_busy(c)};
         3'd3:    return {14'd0, m_sy0, m_sx0};
         3'd4:    return {14'd0, m_sy1, m_sx1};
         3'd5:    return {29'd0, m_scol};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      go_cyc = -1; done_cyc = -1; go_pulse = -1;
      m_mode = 1'b0;
      m_sx0 = '0; m_sy0 = '0; m_sx1 = '0; m_sy1 = '0; m_scol = '0;
      m_x0 = '0; m_y0 = '0; m_x1 = '0; m_y1 = '0; m_col = '0;
   endtask

   task automatic model_edge();
      int   c;
      int   n;
      logic wok;
      c   = cyc;
      n   = cyc + 1;
      wok = wr && !m_wait(c);
      if (wr && addr == 3'd2 && !m_busy(c)) begin
         go_cyc = n; done_cyc = -1; go_pulse = n;
         m_x0 = m_sx0; m_y0 = m_sy0; m_x1 = m_sx1; m_y1 = m_sy1; m_col = m_scol;
      end else if (m_busy(c) && done_cyc < 0 && done_w) begin
         done_cyc = n;
      end
      if (wok) begin
         case (addr)
            3'd0: m_mode = wdata[0];
            3'd3: begin m_sx0 = wdata[8:0]; m_sy0 = wdata[17:9]; end
            3'd4: begin m_sx1 = wdata[8:0]; m_sy1 = wdata[17:9]; end
            3'd5: m_scol = wdata[2:0];
            default: ;
         endcase
      end
      cyc = n;
   endtask

   // Advance the model on each edge (or async reset), then compare 1 ns later.
   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else        model_edge();
      #1;
      check("cyc_go",      {31'd0, go},      {31'd0, go_pulse == cyc});
      check("cyc_waitreq", {31'd0, waitreq}, {31'd0, m_wait(cyc)});
      check("cyc_rdata",   rdata,            m_rdata(cyc));
      check("cyc_x0",      {23'd0, x0},      {23'd0, m_x0});
      check("cyc_y0",      {23'd0, y0},      {23'd0, m_y0});
      check("cyc_x1",      {23'd0, x1},      {23'd0, m_x1});
      check("cyc_y1",      {23'd0, y1},      {23'd0, m_y1});
      check("cyc_color",   {29'd0, col},     {29'd0, m_col});
      if (go) go_count++;
   end

   // LDA stand-in: answers each o_GO with a one-cycle DONE after lda_delay
   // cycles; a reset abandons the pending answer.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (go && reset) begin
            for (int k = 0; k < lda_delay && reset; k++) @(negedge clk);
            if (reset) begin
               lda_done = 1'b1;
               @(negedge clk);
               lda_done = 1'b0;
            end
         end
      end
   end

   // ---------------- bus tasks ----------------
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int waits);
      @(negedge clk);
      addr = a; wdata = d; wr = 1'b1;
      #1;
      waits = 0;
      while (waitreq && waits < 200) begin
         @(posedge clk);
         #1;
         waits++;
      end
      if (waits >= 200) check("write_timeout", 32'd1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; rd = 1'b1;
      @(posedge clk);
      #2;
      d  = rdata;
      rd = 1'b0;
   endtask

   task automatic wait_idle();
      logic [31:0] d;
      int          n;
      n = 0;
      do begin
         bus_read(3'd1, d);
         n++;
      end while (d[0] && n < 60);
      check("wait_idle_status", d, 32'd0);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [31:0] d;
      int          w;
      int          wbg;
      int          g0;

      repeat (3) @(negedge clk);
      check("rst_waitreq", {31'd0, waitreq}, 32'd0);
      check("rst_go",      {31'd0, go},      32'd0);
      check("rst_x0",      {23'd0, x0},      32'd0);
      check("rst_y1",      {23'd0, y1},      32'd0);
      check("rst_color",   {29'd0, col},     32'd0);
      check("rst_rdata",   rdata,            32'd0);
      reset = 1'b1;

      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), d);
         check($sformatf("rd_after_reset_a%0d", a), d, 32'd0);
      end

      // Poll-mode line: X0=10, Y0=160, X1=319, Y1=240, colour 5.
      bus_write(3'd0, 32'd1, w);
      bus_write(3'd3, 32'h0001_400A, w);
      bus_write(3'd4, 32'h0001_E13F, w);
      bus_write(3'd5, 32'hFFFF_FFFD, w);
      bus_read(3'd3, d);
      check("rd_start", d, 32'h0001_400A);
      bus_read(3'd5, d);
      check("rd_color", d, 32'd5);
      lda_delay = 3;
      g0 = go_count;
      bus_write(3'd2, 32'hDEAD_BEEF, w);
      check("poll_go_waits", w, 32'd0);
      bus_read(3'd1, d);
      check("poll_status_busy", d, 32'd1);
      wait_idle();
      check("poll_go_pulses", go_count - g0, 32'd1);
      check("poll_x0", {23'd0, x0}, 32'd10);
      check("poll_y0", {23'd0, y0}, 32'd160);
      check("poll_x1", {23'd0, x1}, 32'd319);
      check("poll_y1", {23'd0, y1}, 32'd240);
      check("poll_color", {29'd0, col}, 32'd5);

      // Stall-mode line with a 20-cycle LDA.
      bus_write(3'd0, 32'd0, w);
      lda_delay = 20;
      g0 = go_count;
      bus_write(3'd2, 32'd0, w);
      check("stall_waits", w, 32'd21);
      check("stall_go_pulses", go_count - g0, 32'd1);
      bus_read(3'd1, d);
      check("stall_status_after", d, 32'd0);

      // Poll mode: staging write and second GO while busy are isolated.
      bus_write(3'd0, 32'd1, w);
      lda_delay = 8;
      g0 = go_count;
      bus_write(3'd2, 32'd0, w);
      bus_write(3'd3, 32'h0003_FFFF, w);
      bus_write(3'd2, 32'd0, w);
      check("busy_go_x0_kept", {23'd0, x0}, 32'd10);
      check("busy_go_y0_kept", {23'd0, y0}, 32'd160);
      wait_idle();
      check("busy_go_pulses", go_count - g0, 32'd1);
      lda_delay = 1;
      g0 = go_count;
      bus_write(3'd2, 32'd0, w);
      repeat (2) @(negedge clk);
      check("next_go_x0", {23'd0, x0}, 32'd511);
      check("next_go_y0", {23'd0, y0}, 32'd511);
      check("next_go_pulses", go_count - g0, 32'd1);
      wait_idle();

      // Stray DONE while idle.
      g0 = go_count;
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      bus_read(3'd1, d);
      check("stray_done_status", d, 32'd0);
      check("stray_done_pulses", go_count - g0, 32'd0);

      // Randomised traffic, including minimum-spacing lines in both modes.
      for (int i = 0; i < 60; i++) begin
         lda_delay = $urandom_range(1, 4);
         case ($urandom_range(0, 3))
            0: bus_write(3'($urandom_range(0, 7)), $urandom, w);
            1: bus_read(3'($urandom_range(0, 7)), d);
            2: bus_write(3'd0, {31'd0, 1'($urandom)}, w);
            default: bus_write(3'd2, $urandom, w);
         endcase
      end
      wait_idle();

      // Reset in the middle of a stall-mode line.
      bus_write(3'd0, 32'd0, w);
      lda_delay = 20;
      fork
         bus_write(3'd2, 32'd0, wbg);
      join_none
      repeat (6) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_waitreq", {31'd0, waitreq}, 32'd0);
      check("midrst_go",      {31'd0, go},      32'd0);
      check("midrst_x0",      {23'd0, x0},      32'd0);
      check("midrst_y0",      {23'd0, y0},      32'd0);
      check("midrst_x1",      {23'd0, x1},      32'd0);
      check("midrst_color",   {29'd0, col},     32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      bus_read(3'd1, d);
      check("midrst_status", d, 32'd0);
      bus_read(3'd0, d);
      check("midrst_mode", d, 32'd0);

      // A fresh stall-mode line after reset: X0=Y0=5.
      bus_write(3'd3, 32'h0000_0A05, w);
      lda_delay = 2;
      g0 = go_count;
      bus_write(3'd2, 32'd0, w);
      check("post_rst_waits", w, 32'd3);
      check("post_rst_pulses", go_count - g0, 32'd1);
      check("post_rst_x0", {23'd0, x0}, 32'd5);
      check("post_rst_y0", {23'd0, y0}, 32'd5);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global time bound.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lda_avalon_slave.md
# lda_avalon_slave

Avalon-MM slave register block that sits directly upstream of the line-drawing algorithm (LDA) core. It holds the line endpoints, colour and mode written by the processor, snapshots them on a start command, and issues a one-cycle go pulse to the LDA. It then tracks completion through the LDA's done pulse, reporting it either by stalling the bus (stall mode) or through a readable status bit (poll mode).

## Interface
Parameters: none (all widths fixed by the LDA and the Avalon bus).

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- i_avs_address  in  3  word address of register
- i_avs_read  in  1  read strobe
- i_avs_write  in  1  write strobe
- i_avs_writedata  in  32  write data
- o_avs_readdata  out  32  read data, combinational, valid while i_avs_read=1
- o_avs_waitrequest  out  1  stall; master holds command while 1
- o_X0, o_Y0, o_X1, o_Y1  out  9 each  latched endpoints to LDA
- o_COLOR  out  3  latched colour to LDA
- o_GO  out  1  one-cycle start pulse to LDA
- i_DONE  in  1  one-cycle completion pulse from LDA

## Operation
- Register map (word addresses):
  - 0 MODE: bit0, 0=stall, 1=poll; R/W
  - 1 STATUS: bit0 busy; read-only
  - 2 GO: write of any data starts a line; reads return 0
  - 3 START: [8:0] X0, [17:9] Y0; R/W
  - 4 END: [8:0] X1, [17:9] Y1; R/W
  - 5 COLOR: [2:0]; R/W
  - 6, 7: reads return 0, writes are ignored.
- Unused writedata bits are ignored. Reads zero-extend to 32 bits.
- Staging registers (MODE, START, END, COLOR) are written whenever i_avs_write=1 and o_avs_waitrequest=0, in any state.
- On GO acceptance, staging values are copied to the o_X0/o_Y0/o_X1/o_Y1/o_COLOR shadow registers. Staging writes during a line never disturb the LDA outputs.
- FSM states: IDLE, BUSY, FINISH.
  - IDLE: a GO write is accepted at the next edge, shadows load, state becomes BUSY, and o_GO=1 for the following cycle only.
  - BUSY: i_DONE=1 moves the state to FINISH.
  - FINISH: unconditionally returns to IDLE after one cycle.
- busy = (state != IDLE).
- o_avs_waitrequest = 1 only when all of the following hold: i_avs_write=1, address=2, MODE.bit0=0, and state is IDLE or BUSY.
  - Effect: a stall-mode GO write is held from issue until FINISH and completes on the FINISH edge.
  - All other accesses never wait.
- Poll mode: GO writes in IDLE complete immediately. GO writes in BUSY or FINISH complete but are ignored (no o_GO, no shadow load).
- i_DONE outside BUSY is ignored.
- MODE changes during BUSY take effect on the next GO.

## Timing
- Reset values:
  - Every register and output is 0: o_GO, endpoints, o_COLOR, o_avs_waitrequest, and o_avs_readdata (no read).
  - MODE=stall; state=IDLE.
- Reset mid-line: the FSM returns to IDLE immediately and any pending stall releases. The LDA's own reset is driven independently.
- GO accepted at edge T:
  - o_GO is high during cycle T..T+1 only.
  - STATUS reads 1 from T through the FINISH cycle.
- i_DONE sampled at edge D gives FINISH in cycle D..D+1.
  - Stall mode: waitrequest drops in that cycle and the transaction completes at edge D+1.
  - STATUS reads 0 from D+1.
- Minimum GO-to-GO spacing is 3 edges (GO accept, DONE, FINISH), given a single-cycle LDA.

## Test plan
- Reset, then read addresses 0–7: all return 0. All outputs are 0 and waitrequest=0.
- Write START=0x0140A, END=0x1E13F, COLOR=5, then GO in poll mode:
  - One o_GO pulse.
  - Outputs show X0=10, Y0=160, X1=319, Y1=240, COLOR=5.
  - STATUS=1 until 1 cycle after i_DONE, then 0.
- Stall mode GO with i_DONE returned 20 cycles later: waitrequest holds high for 21 cycles, drops in FINISH, and exactly one o_GO pulse is issued.
- Poll mode, write START=0x3FFFF and a second GO while BUSY:
  - o_X0/o_Y0 remain unchanged and no second o_GO is issued.
  - The next GO after completion drives X0=511, Y0=511.
- Stray i_DONE in IDLE: no state change, STATUS stays 0.
- Assert reset in BUSY during a stall-mode GO: waitrequest=0, STATUS=0, and all outputs cleared immediately (asynchronously). A subsequent GO works normally.
